ram_access_ctrl: RTL and testbench

//  Sits directly upstream of the 1024x10 RAM and owns its address, write-enable and write-data pins.

---
 rtl/ram_ctrl_pkg.sv | 19 +
 rtl/burst_addr_gen.sv | 36 +++
 rtl/ram_access_ctrl.sv | 103 ++++++++++
 tb/tb_ram_access_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types for the RAM access controller.
// Default widths, FSM state encoding and the RAM command bundle.
package ram_ctrl_pkg;

   localparam int RAM_ADDR_W = 10;
   localparam int RAM_DATA_W = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic                  we;
      logic [RAM_ADDR_W-1:0] addr;
      logic [RAM_DATA_W-1:0] wdata;
   } ram_cmd_t;

endpackage

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: loader write pointer and remaining-word counter.
// Ports: clk, reset, load/base/len (start burst), step (word taken), ptr, last.
module burst_addr_gen #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] len,
   input  logic              step,
   output logic [ADDR_W-1:0] ptr,
   output logic              last
);

   // One extra bit so a zero length can stand for a full 2**ADDR_W sweep.
   logic [ADDR_W:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
         cnt <= '0;
      end else if (load) begin
         ptr <= base;
         cnt <= (len == '0) ? {1'b1, {ADDR_W{1'b0}}}
                            : {1'b0, len};
      end else if (step) begin
         // Natural ADDR_W-bit overflow gives the top-to-zero wrap.
         ptr <= ptr + 1'b1;
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: owns the RAM pins; CPU single-word port has priority
// over a valid/ready burst loader. Ports: a_* CPU, b_* loader, ram_* RAM.
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_start,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] b_len,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              b_busy,
   output logic              b_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   ctrl_state_t       state;
   ram_cmd_t          cmd;
   logic              accept;
   logic              load;
   logic              last;
   logic [ADDR_W-1:0] ptr;

   assign b_busy  = (state == BURST);
   assign b_ready = b_busy & ~a_req;
   assign accept  = b_ready & b_valid;
   assign load    = b_start & ~b_busy;

   burst_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .base  (b_base),
      .len   (b_len),
      .step  (accept),
      .ptr   (ptr),
      .last  (last)
   );

   // Reset also parks the bus so a CPU request cannot write during reset.
   always_comb begin
      cmd = '0;
      if (!reset && a_req) begin
         cmd.we    = a_we;
         cmd.addr  = a_addr;
         cmd.wdata = a_wdata;
      end else if (!reset && accept) begin
         cmd.we    = 1'b1;
         cmd.addr  = ptr;
         cmd.wdata = b_data;
      end
   end

   assign ram_we    = cmd.we;
   assign ram_addr  = cmd.addr;
   assign ram_wdata = cmd.wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         a_ack   <= 1'b0;
         a_rdata <= '0;
         b_done  <= 1'b0;
      end else begin
         a_ack  <= a_req;
         b_done <= accept & last;
         // Captured before the clocked write lands: read-before-write.
         if (a_req) begin
            a_rdata <= ram_rdata;
         end
         unique case (state)
            IDLE: begin
               if (b_start) begin
                  state <= BURST;
               end
            end
            BURST: begin
               if (accept && last) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed and random checks of ram_access_ctrl
// against a word-level model of the RAM and both masters.
module tb_ram_access_ctrl;

   localparam int AW    = 10;
   localparam int DW    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req, a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_ack;
   logic [DW-1:0] a_rdata;
   logic          b_start;
   logic [AW-1:0] b_base, b_len;
   logic          b_valid;
   logic [DW-1:0] b_data;
   logic          b_ready, b_busy, b_done;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_access_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_ack     (a_ack),
      .a_rdata   (a_rdata),
      .b_start   (b_start),
      .b_base    (b_base),
      .b_len     (b_len),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .b_busy    (b_busy),
      .b_done    (b_done),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // The RAM itself: combinational read, clocked write.
   logic [DW-1:0] ram [DEPTH] = '{default: '0};
   assign ram_rdata = ram[ram_addr];
   always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

   // Reference model state.
   logic [DW-1:0] mm [DEPTH];
   bit            m_busy;
   int            m_ptr;
   int            m_rem;
   logic [DW-1:0] m_rdata;
   bit            m_ack;
   bit            m_done;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input bit start, input logic [AW-1:0] base,
                       input logic [AW-1:0] len, input bit valid,
                       input logic [DW-1:0] data);
      bit rdy, acc, was_busy, ewe;
      int eaddr, ewd;
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
      b_start = start; b_base = base; b_len = len;
      b_valid = valid; b_data = data;
      @(negedge clk);
      was_busy = m_busy;
      rdy = m_busy && !req;
      acc = rdy && valid;
      ewe = 1'b0; eaddr = 0; ewd = 0;
      if (req) begin
         ewe = we; eaddr = int'(addr); ewd = int'(wdata);
      end else if (acc) begin
         ewe = 1'b1; eaddr = m_ptr; ewd = int'(data);
      end
      chk("b_ready", 32'(b_ready), 32'(rdy));
      chk("ram_we", 32'(ram_we), 32'(ewe));
      chk("ram_addr", 32'(ram_addr), eaddr);
      chk("ram_wdata", 32'(ram_wdata), ewd);
      m_ack = req;
      if (req) begin
         m_rdata = mm[addr];
         if (we) mm[addr] = wdata;
      end
      m_done = 1'b0;
      if (acc) begin
         mm[m_ptr] = data;
         m_ptr = (m_ptr + 1) % DEPTH;
         m_rem--;
         if (m_rem == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end
      if (start && !was_busy) begin
         m_busy = 1'b1;
         m_ptr = int'(base);
         m_rem = (len == 0) ? DEPTH : int'(len);
      end
      @(posedge clk);
      #1;
      chk("a_ack", 32'(a_ack), 32'(m_ack));
      chk("a_rdata", 32'(a_rdata), 32'(m_rdata));
      chk("b_busy", 32'(b_busy), 32'(m_busy));
      chk("b_done", 32'(b_done), 32'(m_done));
   endtask

   task automatic idle();
      step(0, 0, '0, '0, 0, '0, '0, 0, '0);
   endtask

   task automatic check_ram();
      for (int i = 0; i < DEPTH; i++) chk("ram_word", 32'(ram[i]), 32'(mm[i]));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_a_ack"}, 32'(a_ack), 32'd0);
      chk({tag, "_a_rdata"}, 32'(a_rdata), 32'd0);
      chk({tag, "_b_busy"}, 32'(b_busy), 32'd0);
      chk({tag, "_b_done"}, 32'(b_done), 32'd0);
      chk({tag, "_b_ready"}, 32'(b_ready), 32'd0);
      chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      m_busy = 0; m_ptr = 0; m_rem = 0;
      m_rdata = '0; m_ack = 0; m_done = 0;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_start = 0; b_base = '0; b_len = '0; b_valid = 0; b_data = '0;
      reset = 1'b1;
      #2;
      check_all_zero("reset");
      #10;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // CPU write then read back.
      step(1, 1, 10'h005, 10'h2AA, 0, '0, '0, 0, '0);
      step(1, 0, 10'h005, '0, 0, '0, '0, 0, '0);
      idle();

      // Four-word burst wrapping past the top address.
      step(0, 0, '0, '0, 1, 10'h3FE, 10'd4, 0, '0);
      for (int i = 1; i <= 4; i++) step(0, 0, '0, '0, 0, '0, '0, 1, 10'(i));
      idle();
      chk("wrap_3fe", 32'(ram[10'h3FE]), 32'd1);
      chk("wrap_001", 32'(ram[10'h001]), 32'd4);

      // CPU stalls the loader for two cycles mid-burst.
      step(0, 0, '0, '0, 1, 10'h020, 10'd6, 0, '0);
      step(0, 0, '0, '0, 0, '0, '0, 1, 10'h0A1);
      step(0, 0, '0, '0, 0, '0, '0, 1, 10'h0A2);
      step(1, 1, 10'h021, 10'h155, 0, '0, '0, 1, 10'h0A3);
      step(1, 0, 10'h020, '0, 0, '0, '0, 1, 10'h0A3);
      for (int i = 3; i <= 6; i++) step(0, 0, '0, '0, 0, '0, '0, 1, 10'(10'h0A0 + i));
      idle();

      // Zero length means a full sweep; a restart while busy is ignored.
      step(0, 0, '0, '0, 1, 10'h200, 10'd0, 0, '0);
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, '0, '0, (i == 500), 10'h000, 10'd3, 1,
              10'((i * 7 + 3) % DEPTH));
      end
      idle();
      check_ram();

      // Reset two words into a five-word burst.
      step(0, 0, '0, '0, 1, 10'h100, 10'd5, 0, '0);
      step(0, 0, '0, '0, 0, '0, '0, 1, 10'h011);
      step(0, 0, '0, '0, 0, '0, '0, 1, 10'h012);
      a_req = 1; a_we = 1; a_addr = 10'h007; a_wdata = 10'h005;
      b_valid = 1; b_data = 10'h013;
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      m_busy = 0; m_rdata = '0; m_ack = 0; m_done = 0;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_valid = 0; b_data = '0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, '0, '0, 1, 10'h3C3);
      step(0, 0, '0, '0, 1, 10'h100, 10'd2, 0, '0);
      step(0, 0, '0, '0, 0, '0, '0, 1, 10'h021);
      step(0, 0, '0, '0, 0, '0, '0, 1, 10'h022);
      idle();

      // Write then immediate read of the same word; back-to-back reads.
      step(1, 1, 10'h040, 10'h155, 0, '0, '0, 0, '0);
      step(1, 0, 10'h040, '0, 0, '0, '0, 0, '0);
      step(1, 0, 10'h005, '0, 0, '0, '0, 0, '0);
      step(1, 0, 10'h3FE, '0, 0, '0, '0, 0, '0);
      idle();

      // Random mix of CPU traffic and short bursts near the wrap point.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 4) == 0, $urandom % 2,
              10'(($urandom_range(0, 40) + 1000) % DEPTH), 10'($urandom),
              ($urandom % 20) == 0,
              10'(($urandom_range(0, 40) + 1000) % DEPTH),
              10'($urandom_range(1, 12)),
              ($urandom % 3) != 0, 10'($urandom));
      end
      for (int i = 0; i < 16; i++) step(0, 0, '0, '0, 0, '0, '0, 1, 10'h2F0);
      idle();
      check_ram();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
